ibex_multdiv_seq: RTL and testbench
===================================

# ibex_multdiv_seq

Iterative multiply/divide sequencer for the RV32M instructions. It owns no adder. Every addition and subtraction, including absolute value, partial-product accumulation, trial subtraction and sign fix-up, runs on the ALU's shared 33-bit adder through the ALU's multdiv operand port. It sits beside the ALU in the execute stage. The decoder starts it with an operation and two operands, and it returns one registered 32-bit result after a fixed latency.

## Interface
Parameters:
- None. Width fixed at 32 bits, iteration count fixed at 32.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  operation request; held high by the requester until valid_o.
- op_i  in  3  md_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7 (RISC-V funct3).
- op_a_i  in  32  rs1 operand.
- op_b_i  in  32  rs2 operand.
- alu_en_o  out  1  selects multdiv operands on the ALU adder (drives the ALU's multdiv enable).
- alu_operand_a_o  out  33  adder input A; bit 0 is the carry-injection bit.
- alu_operand_b_o  out  33  adder input B; bit 0 is the carry-injection bit.
- alu_adder_ext_i  in  34  ALU adder A+B. The sum field S = alu_adder_ext_i[33:1] is 33 bits; S[32] is the carry-out.
- result_o  out  32  result; registered and held until the next start.
- valid_o  out  1  one-cycle pulse; result_o is valid.

## Operation
Adder usage:
- Add x+y: A={x,0}, B={y,0}.
- Subtract x−y: A={x,1}, B={~y,1}. S[32]=1 means x≥y (unsigned).
- Negate x: A={~x,1}, B={32'b0,1}.

Operand signedness:
- Signed a: MULH, MULHSU, DIV, REM.
- Signed b: MULH, DIV, REM.
- MUL is treated as fully unsigned.
- sa = a[31] & signed_a; sb = b[31] & signed_b.

Registers: acc[31:0], q[31:0], d[31:0], cnt[4:0], a latched op, and a latched sign flag neg.
- Mult: neg = sa^sb.
- DIV: neg = (sa^sb) & (b≠0).
- REM: neg = sa.
- No sign correction needed: neg=0.

States:
- IDLE: alu_en_o=0. If en_i: latch op_i, q←op_a_i, d←op_b_i, acc←0, cnt←0; go to ABS_A.
- ABS_A: if sa, q←−q via the adder; else q unchanged. Always one cycle. Go to ABS_B.
- ABS_B: same for d with sb. Go to CALC.
- CALC, 32 cycles, cnt 0..31:
  - Mult: A={acc,0}, B={d & {32{q[0]}},0}. acc←S[32:1], q←{S[0],q[31:1]}.
  - Div, with t = {acc[30:0],q[31]}: subtract t−d. If acc[31] | S[32]: acc←S[31:0], q←{q[30:0],1}. Else acc←t, q←{q[30:0],0}.
  - Leave CALC when cnt=31.
- FIX: compute result_o, then go to DONE.
  - MUL: q.
  - MULH*: if neg, ~acc+(q==0) using A={~acc,1}, B={32'b0,q==0}; else acc.
  - DIV*: q, negated if neg.
  - REM*: acc, negated if neg.
- DONE: valid_o=1 for one cycle, go to IDLE. A new start may be accepted on the following cycle.

Behaviour on every state:
- alu_en_o=1 in ABS_A, ABS_B, CALC and FIX; 0 otherwise.
- Operands are 0 when alu_en_o=0.
- Abort: en_i low in any state other than IDLE or DONE → IDLE next cycle. No valid_o; result_o unchanged.

Boundary cases, which need no special logic:
- Divide by zero gives quotient 0xFFFFFFFF and remainder = op_a_i.
- 0x80000000 / −1 gives quotient 0x80000000 and remainder 0.

## Timing
- Reset values: state IDLE, valid_o=0, alu_en_o=0, alu_operand_a_o=0, alu_operand_b_o=0, result_o=0, cnt=0, acc=q=d=0.
- Start edge at cycle T, when IDLE samples en_i=1.
- ABS_A at T+1, ABS_B at T+2, CALC at T+3..T+34, FIX at T+35, valid_o at T+36.
- Latency is 36 cycles for every operation, including MUL.
- Operands are sampled only at the start edge.
- rst_i mid-operation forces the reset values immediately; no valid_o is produced.

## Structure
- Shared package ibex_multdiv_pkg holds:
  - md_op_e (3 bits, values above).
  - md_state_e: IDLE, ABS_A, ABS_B, CALC, FIX, DONE.
  - The constant MD_ITER=32.
- Single module with no sub-module. The counter and sign logic are inline.
- The adder stays in the ALU; this block only generates operands.
- Benches instantiate this block together with the ALU.

## Test plan
- MUL 7×6: valid_o at T+36, result_o=42. alu_en_o high exactly 35 cycles.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0. MULHSU, same operands → 0xFFFFFFFF. MULHU, same operands → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM, same operands → 0.
- DIV 5/0 → 0xFFFFFFFF. REM −5/0 → 0xFFFFFFFB.
- Abort and reset:
  - Drop en_i at CALC cycle 10: no valid_o, IDLE next cycle, result_o unchanged. A following MUL 3×3 → 9.
  - Assert rst_i mid-CALC: all outputs reset immediately.

Source files
------------

// File: rtl/ibex_multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibex_multdiv_pkg
// Purpose  : Shared types and operation-decode helpers for the sequential
//            RV32M multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package ibex_multdiv_pkg;

    // Encoding follows RISC-V funct3 for the M extension.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        CALC  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } md_state_e;

    localparam int unsigned MD_ITER = 32;

    function automatic logic op_signed_a(input md_op_e op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic op_signed_b(input md_op_e op);
        return op inside {MULH, DIV, REM};
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op inside {REM, REMU};
    endfunction

    function automatic logic op_is_mulh(input md_op_e op);
        return op inside {MULH, MULHSU, MULHU};
    endfunction

    // Low product word and quotient live in q; high product and remainder in acc.
    function automatic logic op_result_from_q(input md_op_e op);
        return op inside {MUL, DIV, DIVU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_multdiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ibex_multdiv_seq_if
// Purpose  : Request/result and shared-adder operand bundle between the
//            decoder/ALU side and the multdiv sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ibex_multdiv_seq_if;
    import ibex_multdiv_pkg::*;

    logic        en_i;
    md_op_e      op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;

    logic        alu_en_o;
    logic [32:0] alu_operand_a_o;
    logic [32:0] alu_operand_b_o;
    logic [33:0] alu_adder_ext_i;

    logic [31:0] result_o;
    logic        valid_o;

    // Requester plus ALU adder side.
    modport master (
        output en_i,
        output op_i,
        output op_a_i,
        output op_b_i,
        output alu_adder_ext_i,
        input  alu_en_o,
        input  alu_operand_a_o,
        input  alu_operand_b_o,
        input  result_o,
        input  valid_o
    );

    // Sequencer side.
    modport slave (
        input  en_i,
        input  op_i,
        input  op_a_i,
        input  op_b_i,
        input  alu_adder_ext_i,
        output alu_en_o,
        output alu_operand_a_o,
        output alu_operand_b_o,
        output result_o,
        output valid_o
    );

endinterface
`default_nettype wire

// File: rtl/ibex_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : ibex_multdiv_seq
// Purpose  : Iterative RV32M multiply/divide sequencer; all arithmetic runs on
//            the ALU's shared 33-bit adder, this block only steers operands.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_multdiv_seq
    import ibex_multdiv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    ibex_multdiv_seq_if.slave md
);

    localparam logic [4:0] c_LAST_ITER = 5'(MD_ITER - 1);

    md_state_e   r_state,  w_state_nxt;
    md_op_e      r_op,     w_op_nxt;
    logic [31:0] r_acc,    w_acc_nxt;
    logic [31:0] r_q,      w_q_nxt;
    logic [31:0] r_d,      w_d_nxt;
    logic [4:0]  r_cnt,    w_cnt_nxt;
    logic        r_neg,    w_neg_nxt;
    logic [31:0] r_result, w_result_nxt;

    logic        w_alu_en;
    logic [32:0] w_operand_a;
    logic [32:0] w_operand_b;
    logic        w_valid;

    logic [32:0] w_sum;
    logic        w_sa_start;
    logic        w_sb_start;
    logic        w_neg_start;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_trial;
    logic [31:0] w_pp;
    logic [31:0] w_fix_src;
    logic        w_fix_cin;

    assign w_sum      = md.alu_adder_ext_i[33:1];
    assign w_sa_start = md.op_a_i[31] & op_signed_a(md.op_i);
    assign w_sb_start = md.op_b_i[31] & op_signed_b(md.op_i);

    // Division by zero keeps the all-ones quotient positive; remainder follows the dividend.
    always_comb begin
        w_neg_start = w_sa_start ^ w_sb_start;
        if (op_is_rem(md.op_i)) begin
            w_neg_start = w_sa_start;
        end else if (op_is_div(md.op_i)) begin
            w_neg_start = (w_sa_start ^ w_sb_start) & (md.op_b_i != 32'd0);
        end
    end

    assign w_sa      = r_q[31] & op_signed_a(r_op);
    assign w_sb      = r_d[31] & op_signed_b(r_op);
    assign w_trial   = {r_acc[30:0], r_q[31]};
    assign w_pp      = r_d & {32{r_q[0]}};
    assign w_fix_src = op_result_from_q(r_op) ? r_q : r_acc;
    // High-word negation only carries into acc when the low word is all zero.
    assign w_fix_cin = op_is_mulh(r_op) ? (r_q == 32'd0) : 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_op     <= MUL;
            r_acc    <= 32'd0;
            r_q      <= 32'd0;
            r_d      <= 32'd0;
            r_cnt    <= 5'd0;
            r_neg    <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_acc    <= w_acc_nxt;
            r_q      <= w_q_nxt;
            r_d      <= w_d_nxt;
            r_cnt    <= w_cnt_nxt;
            r_neg    <= w_neg_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_acc_nxt    = r_acc;
        w_q_nxt      = r_q;
        w_d_nxt      = r_d;
        w_cnt_nxt    = r_cnt;
        w_neg_nxt    = r_neg;
        w_result_nxt = r_result;
        w_alu_en     = 1'b0;
        w_operand_a  = 33'd0;
        w_operand_b  = 33'd0;
        w_valid      = 1'b0;

        case (r_state)
            IDLE: begin
                if (md.en_i) begin
                    w_state_nxt = ABS_A;
                    w_op_nxt    = md.op_i;
                    w_q_nxt     = md.op_a_i;
                    w_d_nxt     = md.op_b_i;
                    w_acc_nxt   = 32'd0;
                    w_cnt_nxt   = 5'd0;
                    w_neg_nxt   = w_neg_start;
                end
            end
            ABS_A: begin
                w_alu_en    = 1'b1;
                w_operand_a = {~r_q, 1'b1};
                w_operand_b = {32'd0, 1'b1};
                if (w_sa) begin
                    w_q_nxt = w_sum[31:0];
                end
                w_state_nxt = ABS_B;
            end
            ABS_B: begin
                w_alu_en    = 1'b1;
                w_operand_a = {~r_d, 1'b1};
                w_operand_b = {32'd0, 1'b1};
                if (w_sb) begin
                    w_d_nxt = w_sum[31:0];
                end
                w_state_nxt = CALC;
            end
            CALC: begin
                w_alu_en = 1'b1;
                if (op_is_div(r_op)) begin
                    // acc[31] is the bit shifted out of the 32-bit trial value.
                    w_operand_a = {w_trial, 1'b1};
                    w_operand_b = {~r_d, 1'b1};
                    if (r_acc[31] | w_sum[32]) begin
                        w_acc_nxt = w_sum[31:0];
                        w_q_nxt   = {r_q[30:0], 1'b1};
                    end else begin
                        w_acc_nxt = w_trial;
                        w_q_nxt   = {r_q[30:0], 1'b0};
                    end
                end else begin
                    w_operand_a = {r_acc, 1'b0};
                    w_operand_b = {w_pp, 1'b0};
                    w_acc_nxt   = w_sum[32:1];
                    w_q_nxt     = {w_sum[0], r_q[31:1]};
                end
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == c_LAST_ITER) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_alu_en     = 1'b1;
                w_operand_a  = {~w_fix_src, 1'b1};
                w_operand_b  = {32'd0, w_fix_cin};
                w_result_nxt = r_neg ? w_sum[31:0] : w_fix_src;
                w_state_nxt  = DONE;
            end
            DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A withdrawn request abandons the operation and keeps the old result.
        if (!md.en_i && (r_state inside {ABS_A, ABS_B, CALC, FIX})) begin
            w_state_nxt  = IDLE;
            w_result_nxt = r_result;
        end
    end

    assign md.alu_en_o        = w_alu_en;
    assign md.alu_operand_a_o = w_operand_a;
    assign md.alu_operand_b_o = w_operand_b;
    assign md.valid_o         = w_valid;
    assign md.result_o        = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_multdiv_seq
// Purpose  : Self-checking bench for the multdiv sequencer with a modelled
//            ALU adder and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_multdiv_seq;
    import ibex_multdiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_fail = 0;

    ibex_multdiv_seq_if mif();

    ibex_multdiv_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .md    (mif.slave)
    );

    always #5 clk = ~clk;

    // ALU shared adder.
    assign mif.alu_adder_ext_i = {1'b0, mif.alu_operand_a_o} + {1'b0, mif.alu_operand_b_o};

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa64, sb64, ua64, ub64;
        logic [63:0] p;
        int          ai, bi;
        logic [31:0] r;
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        ua64 = longint'({32'h0, a});
        ub64 = longint'({32'h0, b});
        ai   = $signed(a);
        bi   = $signed(b);
        p    = 64'd0;
        r    = 32'd0;
        case (op)
            3'd0: begin p = ua64 * ub64; r = p[31:0];  end
            3'd1: begin p = sa64 * sb64; r = p[63:32]; end
            3'd2: begin p = sa64 * ub64; r = p[63:32]; end
            3'd3: begin p = ua64 * ub64; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = ai / bi;
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = ai % bi;
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle-level reference: 0 = idle, 1..35 = busy cycles after start, 36 = result cycle.
    int          m_phase   = 0;
    logic [31:0] m_result  = 32'd0;
    logic [31:0] m_pending = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_result <= 32'd0;
        end else if (m_phase == 0) begin
            if (mif.en_i) begin
                m_phase   <= 1;
                m_pending <= ref_result(mif.op_i, mif.op_a_i, mif.op_b_i);
            end
        end else if (m_phase == 36) begin
            m_phase <= 0;
        end else if (!mif.en_i) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase == 35) m_result <= m_pending;
        end
    end

    always @(negedge clk) begin
        check("valid_o", 64'(mif.valid_o), 64'(m_phase == 36));
        check("alu_en_o", 64'(mif.alu_en_o), 64'(m_phase >= 1 && m_phase <= 35));
        check("result_o", 64'(mif.result_o), 64'(m_result));
        if (!(m_phase >= 1 && m_phase <= 35)) begin
            check("operand_a_idle", 64'(mif.alu_operand_a_o), 64'd0);
            check("operand_b_idle", 64'(mif.alu_operand_b_o), 64'd0);
        end
    end

    task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        int en_cnt;
        bit seen;
        @(negedge clk);
        mif.en_i   = 1'b1;
        mif.op_i   = op;
        mif.op_a_i = a;
        mif.op_b_i = b;
        cyc    = 0;
        en_cnt = 0;
        seen   = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                // Operands must only matter at the start edge.
                mif.op_a_i = ~a;
                mif.op_b_i = a ^ b ^ 32'h5A5A_0001;
                mif.op_i   = md_op_e'(3'(op + 3'd3));
            end
            if (mif.alu_en_o) en_cnt++;
            if (mif.valid_o) seen = 1'b1;
        end
        check({name, "_valid_seen"}, 64'(seen), 64'd1);
        check({name, "_latency"}, 64'(cyc), 64'd36);
        check({name, "_alu_en_cycles"}, 64'(en_cnt), 64'd35);
        check({name, "_result"}, 64'(mif.result_o), 64'(exp));
        check({name, "_model"}, 64'(ref_result(op, a, b)), 64'(exp));
        mif.en_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst        = 1'b1;
        mif.en_i   = 1'b0;
        mif.op_i   = MUL;
        mif.op_a_i = 32'd0;
        mif.op_b_i = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_result", 64'(mif.result_o), 64'd0);
        check("reset_valid", 64'(mif.valid_o), 64'd0);
        check("reset_alu_en", 64'(mif.alu_en_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_7x6",      MUL,    32'd7,          32'd6,          32'd42);
        run_op("mulh_m1",      MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000);
        run_op("mulhsu_m1",    MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("mulhu_max",    MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
        run_op("mulh_min2",    MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000);
        run_op("mulhu_carry",  MULHU,  32'h8000_0000,  32'd2,          32'h0000_0001);
        run_op("div_m7_2",     DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
        run_op("rem_m7_2",     REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
        run_op("divu_100_7",   DIVU,   32'd100,        32'd7,          32'd14);
        run_op("remu_100_7",   REMU,   32'd100,        32'd7,          32'd2);
        run_op("div_m100_7",   DIV,    32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2);
        run_op("rem_m100_7",   REM,    32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE);
        run_op("div_ovf",      DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        run_op("rem_ovf",      REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000);
        run_op("remu_5_0",     REMU,   32'd5,          32'd0,          32'd5);
        run_op("div_5_0",      DIV,    32'd5,          32'd0,          32'hFFFF_FFFF);
        run_op("rem_m5_0",     REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB);

        // Abort during CALC iteration 10.
        @(negedge clk);
        mif.en_i   = 1'b1;
        mif.op_i   = DIVU;
        mif.op_a_i = 32'd1000;
        mif.op_b_i = 32'd3;
        repeat (13) @(negedge clk);
        mif.en_i = 1'b0;
        @(negedge clk);
        check("abort_alu_en", 64'(mif.alu_en_o), 64'd0);
        check("abort_valid", 64'(mif.valid_o), 64'd0);
        check("abort_result_kept", 64'(mif.result_o), 64'hFFFF_FFFB);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.valid_o) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'd0);

        run_op("mul_3x3",      MUL,    32'd3,          32'd3,          32'd9);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        mif.en_i   = 1'b1;
        mif.op_i   = MULHU;
        mif.op_a_i = 32'h1234_5678;
        mif.op_b_i = 32'h9ABC_DEF0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_result", 64'(mif.result_o), 64'd0);
        check("rst_alu_en", 64'(mif.alu_en_o), 64'd0);
        check("rst_operand_a", 64'(mif.alu_operand_a_o), 64'd0);
        check("rst_operand_b", 64'(mif.alu_operand_b_o), 64'd0);
        check("rst_valid", 64'(mif.valid_o), 64'd0);
        @(negedge clk);
        mif.en_i = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        run_op("divu_after_rst", DIVU, 32'd100,        32'd7,          32'd14);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
